cache_line_buffer: RTL and testbench
====================================

# cache_line_buffer

Parametrised storage for one cache data line, the next generation of the per-byte data registers in the 4-way set-associative cache. Holds `LINE_BYTES` bytes, accepts byte-masked CPU writes one beat at a time, and runs a multi-beat refill from memory with a valid/ready handshake that starts at the critical beat and wraps. Provides a registered beat-wide read port and a line-valid flag. One instance sits behind each way/set data slot.

## Interface
- `LINE_BYTES`, default 16: bytes per line; power of two, ≥ `BEAT_BYTES`.
- `BEAT_BYTES`, default 4: bytes per beat; power of two; divides `LINE_BYTES`.
- Derived: `NBEATS = LINE_BYTES/BEAT_BYTES`, `OFF_W = clog2(LINE_BYTES)`, `BW = 8*BEAT_BYTES`.

- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `fill_start` in 1: begin refill (sampled in IDLE only).
- `fill_offset` in OFF_W: byte offset of critical word; low `clog2(BEAT_BYTES)` bits ignored.
- `fill_valid` in 1: memory beat present.
- `fill_data` in BW: memory beat.
- `fill_ready` out 1: buffer accepts a beat.
- `fill_done` out 1: one-cycle pulse, refill complete.
- `wr_en` in 1: CPU write request.
- `wr_offset` in OFF_W: beat-aligned write address; low bits ignored.
- `wr_be` in BEAT_BYTES: byte enables for `wr_data`.
- `wr_data` in BW: CPU write data.
- `rd_offset` in OFF_W: beat-aligned read address; low bits ignored.
- `rd_data` out BW: registered read data.
- `invalidate` in 1: clear `line_valid`; abort any refill.
- `line_valid` out 1: line holds a complete refill.
- `busy` out 1: high in FILL.

## Operation
- States: IDLE, FILL.
- IDLE + `fill_start`: latch beat index `idx = fill_offset >> clog2(BEAT_BYTES)`; clear `beat_cnt`; clear `line_valid`; go to FILL. Any `wr_en` in that cycle is dropped.
- FILL: `fill_ready = 1`. Each `fill_valid && fill_ready` writes `fill_data` into beat `idx`, sets `idx = (idx+1) mod NBEATS`, and increments `beat_cnt`.
- Completion: the accepting edge of beat `NBEATS-1` returns the block to IDLE, sets `line_valid`, and pulses `fill_done` for exactly one cycle after that edge.
- `fill_valid` low in FILL: no state change; unbounded stalls allowed.
- `wr_en` in IDLE: for each lane `i` with `wr_be[i]`, byte `i` of the addressed beat takes `wr_data[8i+7:8i]`. Other lanes hold. `line_valid` is unchanged.
- `wr_en` in FILL: ignored, with no side effect.
- `invalidate`: clears `line_valid`. In FILL it returns the block to IDLE with no `fill_done`, and a beat presented in the same cycle is not written. It has priority over `fill_start` and completion. Data bytes are not cleared.
- Reset (any time, including mid-fill) → IDLE; all data bytes 0x00; `line_valid=0`, `fill_ready=0`, `fill_done=0`, `busy=0`, `rd_data=0`.

## Timing
- `rd_data` latency is 1 cycle: it shows the beat at the `rd_offset` sampled on the previous edge. It is read-before-write: a write to the same beat on the same edge appears one cycle later.
- `fill_ready` and `busy` are registered from state: high the cycle after `fill_start` and low the cycle after the last beat or `invalidate`.
- A fill with no stalls takes `NBEATS` accept cycles; `fill_done` follows one cycle after the last accept.
- `fill_start` in FILL: ignored.

## Structure
- Package `cache_pkg`:
  - `fill_state_t` enum {IDLE, FILL};
  - helper functions for `NBEATS`/`OFF_W`;
  - the shared `BEAT_BYTES` default.
- Sub-module `byte_lane_reg`: an 8-bit register with async active-low reset and write enable, instanced `LINE_BYTES` times.
- The top module holds the FSM, beat counter, lane write-enable decode and read mux/register.

## Test plan
- Reset mid-fill: after 2 of 4 beats, pulse `reset` low → all outputs 0, `rd_data=0` at every offset, `busy=0`.
- Refill wrap: `fill_offset=0x8`, beats A,B,C,D with no stalls → beats 2,3,0,1 = A,B,C,D; `fill_done` high one cycle after D; `line_valid=1`.
- Stalled fill: `fill_valid` toggling 1,0,0,1,… → exactly 4 writes, single `fill_done`, no duplicates.
- Masked write: line = 0x00…, `wr_offset=0x4`, `wr_be=4'b0101`, `wr_data=0xAABBCCDD` → beat 1 = 0x00BB00DD, other beats unchanged.
- Read-before-write: same edge `wr_en` and `rd_offset` to beat 0 → `rd_data` shows the old value next cycle and the new value the cycle after.
- Invalidate during fill: `invalidate` together with beat 3 → beat not written, no `fill_done`, `line_valid=0`, IDLE; a later `wr_en` is accepted.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg -- shared types and sizing helpers for the cache data-line storage.
//   fill_state_t   : refill FSM states (IDLE, FILL)
//   BEAT_BYTES_DEF : default beat width in bytes
//   nbeats()/off_w(): derived geometry helpers used for parameter math
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int BEAT_BYTES_DEF = 4;

  function automatic int nbeats(input int line_bytes, input int beat_bytes);
    return line_bytes / beat_bytes;
  endfunction

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

endpackage

// File: rtl/byte_lane_reg.sv
// byte_lane_reg -- one data byte of a cache line.
//   i_clk   : clock
//   i_rst_n : async active-low reset, clears the byte to 0x00
//   i_we    : load i_d on the rising edge
//   i_d     : next byte value
//   o_q     : stored byte
module byte_lane_reg (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);

  logic [7:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_q <= 8'h00;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/cache_line_buffer.sv
// cache_line_buffer -- storage for one cache data line.
//   i_clk, i_reset (async, active-low)
//   Refill : i_fill_start/i_fill_offset start a wrapping burst at the critical
//            beat; i_fill_valid/i_fill_data with o_fill_ready handshake;
//            o_fill_done pulses once after the last beat.
//   CPU    : i_wr_en/i_wr_offset/i_wr_be/i_wr_data byte-masked beat write (IDLE only)
//   Read   : i_rd_offset -> o_rd_data, one-cycle registered, read-before-write
//   Status : i_invalidate clears o_line_valid and aborts a refill;
//            o_busy high while filling.
module cache_line_buffer
  import cache_pkg::*;
#(
  parameter  int LINE_BYTES = 16,
  parameter  int BEAT_BYTES = BEAT_BYTES_DEF,
  localparam int NBEATS     = nbeats(LINE_BYTES, BEAT_BYTES),
  localparam int OFF_W      = off_w(LINE_BYTES),
  localparam int BW         = 8 * BEAT_BYTES
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fill_start,
  input  logic [OFF_W-1:0]      i_fill_offset,
  input  logic                  i_fill_valid,
  input  logic [BW-1:0]         i_fill_data,
  output logic                  o_fill_ready,
  output logic                  o_fill_done,
  input  logic                  i_wr_en,
  input  logic [OFF_W-1:0]      i_wr_offset,
  input  logic [BEAT_BYTES-1:0] i_wr_be,
  input  logic [BW-1:0]         i_wr_data,
  input  logic [OFF_W-1:0]      i_rd_offset,
  output logic [BW-1:0]         o_rd_data,
  input  logic                  i_invalidate,
  output logic                  o_line_valid,
  output logic                  o_busy
);

  localparam int BOFF  = $clog2(BEAT_BYTES);
  localparam int IDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  fill_state_t r_state;
  idx_t        r_idx;        // beat the next fill beat lands in
  idx_t        r_cnt;        // beats accepted so far in this refill
  logic        r_line_valid;
  logic        r_fill_done;
  logic [BW-1:0] r_rd_data;

  logic w_fill, w_start, w_accept, w_last, w_cpu_wr;
  idx_t w_fill_idx, w_wr_idx, w_rd_idx, w_idx_nxt;

  logic [LINE_BYTES-1:0][7:0] w_bytes;
  logic [NBEATS-1:0][BW-1:0]  w_beats;

  assign w_fill     = (r_state == FILL);
  // invalidate outranks a new refill request
  assign w_start    = !w_fill && i_fill_start && !i_invalidate;
  // a beat arriving with invalidate is discarded
  assign w_accept   = w_fill && i_fill_valid && !i_invalidate;
  assign w_last     = (r_cnt == idx_t'(NBEATS - 1));
  // CPU writes only land in IDLE, and lose to a refill starting that cycle
  assign w_cpu_wr   = !w_fill && i_wr_en && !w_start;

  assign w_fill_idx = idx_t'(i_fill_offset >> BOFF);
  assign w_wr_idx   = idx_t'(i_wr_offset >> BOFF);
  assign w_rd_idx   = idx_t'(i_rd_offset >> BOFF);
  assign w_idx_nxt  = (r_idx == idx_t'(NBEATS - 1)) ? '0 : r_idx + 1'b1;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_line_valid <= 1'b0;
      r_fill_done  <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      if (i_invalidate) begin
        r_line_valid <= 1'b0;
        r_state      <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (i_fill_start) begin
            r_idx        <= w_fill_idx;
            r_cnt        <= '0;
            r_line_valid <= 1'b0;
            r_state      <= FILL;
          end
          FILL: if (i_fill_valid) begin
            r_idx <= w_idx_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state      <= IDLE;
              r_line_valid <= 1'b1;
              r_fill_done  <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_byte
    localparam int BEAT = b / BEAT_BYTES;
    localparam int LANE = b % BEAT_BYTES;
    logic       w_we;
    logic [7:0] w_d;

    assign w_we = (w_accept && (r_idx == idx_t'(BEAT))) ||
                  (w_cpu_wr && (w_wr_idx == idx_t'(BEAT)) && i_wr_be[LANE]);
    // fill and CPU writes are mutually exclusive by state
    assign w_d  = w_fill ? i_fill_data[8*LANE +: 8] : i_wr_data[8*LANE +: 8];

    byte_lane_reg u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_reset),
      .i_we    (w_we),
      .i_d     (w_d),
      .o_q     (w_bytes[b])
    );
  end

  // byte b of the flat line is lane (b % BEAT_BYTES) of beat (b / BEAT_BYTES)
  assign w_beats = w_bytes;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_rd_data <= '0;
    else          r_rd_data <= w_beats[w_rd_idx];
  end

  assign o_fill_ready = w_fill;
  assign o_busy       = w_fill;
  assign o_fill_done  = r_fill_done;
  assign o_line_valid = r_line_valid;
  assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_cache_line_buffer.sv
module tb_cache_line_buffer;

  localparam int LB = 16;
  localparam int BB = 4;
  localparam int NB = LB / BB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fill_start, fill_valid, wr_en, invalidate;
  logic [3:0]  fill_offset, wr_offset, rd_offset, wr_be;
  logic [31:0] fill_data, wr_data;
  logic        fill_ready, fill_done, line_valid, busy;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  cache_line_buffer #(.LINE_BYTES(LB), .BEAT_BYTES(BB)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_fill_start(fill_start), .i_fill_offset(fill_offset),
    .i_fill_valid(fill_valid), .i_fill_data(fill_data),
    .o_fill_ready(fill_ready), .o_fill_done(fill_done),
    .i_wr_en(wr_en), .i_wr_offset(wr_offset), .i_wr_be(wr_be), .i_wr_data(wr_data),
    .i_rd_offset(rd_offset), .o_rd_data(rd_data),
    .i_invalidate(invalidate), .o_line_valid(line_valid), .o_busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: line bytes, valid flag, and the list of beats a refill still owes
  byte unsigned m_mem[LB];
  bit           m_lv;
  bit           m_done;
  int           m_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_beat(input int b);
    logic [31:0] r;
    for (int k = 0; k < BB; k++) r[8*k +: 8] = m_mem[b*BB + k];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < LB; i++) m_mem[i] = 8'h00;
    m_lv = 0; m_done = 0; m_q.delete();
  endtask

  task automatic idle_in();
    fill_start = 0; fill_offset = 0; fill_valid = 0; fill_data = 0;
    wr_en = 0; wr_offset = 0; wr_be = 0; wr_data = 0;
    rd_offset = 0; invalidate = 0;
  endtask

  // advance one clock: update the model from current inputs, then check all outputs
  task automatic tick();
    logic [31:0] e_rd;
    bit filling, start;
    int b;
    e_rd    = m_beat(int'(rd_offset) / BB);
    filling = (m_q.size() != 0);
    start   = !filling && fill_start && !invalidate;
    m_done  = 0;
    if (!filling && wr_en && !start)
      for (int k = 0; k < BB; k++)
        if (wr_be[k]) m_mem[(int'(wr_offset) / BB)*BB + k] = wr_data[8*k +: 8];
    if (filling && fill_valid && !invalidate) begin
      b = m_q.pop_front();
      for (int k = 0; k < BB; k++) m_mem[b*BB + k] = fill_data[8*k +: 8];
      if (m_q.size() == 0) begin m_lv = 1; m_done = 1; end
    end
    if (invalidate) begin
      m_lv = 0; m_q.delete();
    end else if (start) begin
      m_lv = 0;
      for (int k = 0; k < NB; k++) m_q.push_back(((int'(fill_offset) / BB) + k) % NB);
    end
    @(posedge clk); #1;
    chk("rd_data",    rd_data,    e_rd);
    chk("fill_done",  fill_done,  m_done);
    chk("line_valid", line_valid, m_lv);
    chk("busy",       busy,       m_q.size() != 0);
    chk("fill_ready", fill_ready, m_q.size() != 0);
  endtask

  typedef struct {
    logic        fs; logic [3:0] fo; logic fv; logic [31:0] fd;
    logic        we; logic [3:0] wo; logic [3:0] be; logic [31:0] wd;
    logic [3:0]  ro; logic inv;
    logic [31:0] e_rd; logic e_done; logic e_lv; logic e_busy;
  } vec_t;

  vec_t tbl[15];
  int   done_cnt;

  initial begin
    // fs fo fv fd  we wo be wd  ro inv | e_rd e_done e_lv e_busy
    tbl[0]  = '{0,0,0,0,            1,4'h4,4'b0101,32'hAABBCCDD, 4'h4,0, 32'h0,        0,0,0};
    tbl[1]  = '{0,0,0,0,            0,0,0,0,                     4'h4,0, 32'h00BB00DD, 0,0,0};
    tbl[2]  = '{0,0,0,0,            0,0,0,0,                     4'h0,0, 32'h0,        0,0,0};
    tbl[3]  = '{0,0,0,0,            0,0,0,0,                     4'h8,0, 32'h0,        0,0,0};
    tbl[4]  = '{1,4'h8,0,0,         0,0,0,0,                     4'h4,0, 32'h00BB00DD, 0,0,1};
    tbl[5]  = '{0,0,1,32'h11111111, 0,0,0,0,                     4'h8,0, 32'h0,        0,0,1};
    tbl[6]  = '{0,0,1,32'h22222222, 0,0,0,0,                     4'h8,0, 32'h11111111, 0,0,1};
    tbl[7]  = '{0,0,1,32'h33333333, 0,0,0,0,                     4'h0,0, 32'h0,        0,0,1};
    tbl[8]  = '{0,0,1,32'h44444444, 0,0,0,0,                     4'h4,0, 32'h00BB00DD, 1,1,0};
    tbl[9]  = '{0,0,0,0,            0,0,0,0,                     4'h0,0, 32'h33333333, 0,1,0};
    tbl[10] = '{0,0,0,0,            0,0,0,0,                     4'h5,0, 32'h44444444, 0,1,0};
    tbl[11] = '{0,0,0,0,            0,0,0,0,                     4'hC,0, 32'h22222222, 0,1,0};
    tbl[12] = '{0,0,0,0,            1,4'h0,4'hF,32'h55555555,    4'h0,0, 32'h33333333, 0,1,0};
    tbl[13] = '{0,0,0,0,            0,0,0,0,                     4'h0,0, 32'h55555555, 0,1,0};
    tbl[14] = '{0,0,0,0,            0,0,0,0,                     4'h8,1, 32'h11111111, 0,0,0};

    idle_in();
    m_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_data",    rd_data,    32'h0);
    chk("rst_fill_done",  fill_done,  1'b0);
    chk("rst_line_valid", line_valid, 1'b0);
    chk("rst_busy",       busy,       1'b0);
    chk("rst_fill_ready", fill_ready, 1'b0);
    rst_n = 1;

    // table vectors: masked write, wrap refill from beat 2, read-before-write
    for (int i = 0; i < 15; i++) begin
      fill_start = tbl[i].fs; fill_offset = tbl[i].fo;
      fill_valid = tbl[i].fv; fill_data   = tbl[i].fd;
      wr_en = tbl[i].we; wr_offset = tbl[i].wo; wr_be = tbl[i].be; wr_data = tbl[i].wd;
      rd_offset = tbl[i].ro; invalidate = tbl[i].inv;
      tick();
      chk($sformatf("vec%0d_rd", i),    rd_data,    tbl[i].e_rd);
      chk($sformatf("vec%0d_done", i),  fill_done,  tbl[i].e_done);
      chk($sformatf("vec%0d_valid", i), line_valid, tbl[i].e_lv);
      chk($sformatf("vec%0d_busy", i),  busy,       tbl[i].e_busy);
    end
    idle_in();

    // reset in the middle of a refill
    fill_start = 1; fill_offset = 4'h0; tick(); idle_in();
    fill_valid = 1; fill_data = 32'hDEADBEEF; tick();
    fill_data = 32'hCAFEF00D; tick(); idle_in();
    rst_n = 0; #2;
    m_reset();
    chk("midrst_rd",    rd_data,    32'h0);
    chk("midrst_busy",  busy,       1'b0);
    chk("midrst_ready", fill_ready, 1'b0);
    chk("midrst_valid", line_valid, 1'b0);
    chk("midrst_done",  fill_done,  1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k <= NB; k++) begin
      rd_offset = 4'(k * BB);
      tick();
    end

    // stalled refill: valid pattern 1,0,0,1,... gives exactly one done
    idle_in();
    fill_start = 1; fill_offset = 4'h4; tick(); idle_in();
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      fill_valid = (c % 3 == 0);
      fill_data  = $urandom;
      fill_start = (c == 1);  // must be ignored while filling
      tick();
      if (fill_done) done_cnt++;
    end
    idle_in();
    for (int k = 0; k < NB; k++) begin
      rd_offset = 4'(k * BB); tick();
      if (fill_done) done_cnt++;
    end
    chk("stall_done_cnt", done_cnt, 1);

    // invalidate on the final beat: beat dropped, no done, back to IDLE
    fill_start = 1; fill_offset = 4'h0; tick(); idle_in();
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      fill_valid = 1; fill_data = 32'h0A0B0C00 + c; tick();
      if (fill_done) done_cnt++;
    end
    fill_valid = 1; fill_data = 32'h99999999; invalidate = 1; tick();
    if (fill_done) done_cnt++;
    idle_in();
    rd_offset = 4'hC; tick();
    if (fill_done) done_cnt++;
    chk("inv_done_cnt", done_cnt, 0);
    chk("inv_busy",     busy,       1'b0);
    chk("inv_valid",    line_valid, 1'b0);
    wr_en = 1; wr_offset = 4'hC; wr_be = 4'hF; wr_data = 32'h76543210; tick();
    idle_in(); rd_offset = 4'hC; tick();
    tick();
    chk("inv_later_wr", rd_data, 32'h76543210);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      idle_in();
      rd_offset = 4'($urandom);
      if (m_q.size() == 0) begin
        fill_start  = ($urandom_range(0, 7) == 0);
        fill_offset = 4'($urandom);
        wr_en       = !fill_start && ($urandom_range(0, 1) == 1);
        invalidate  = !fill_start && !wr_en && ($urandom_range(0, 15) == 0);
      end else begin
        fill_valid  = $urandom_range(0, 1);
        fill_start  = $urandom_range(0, 1);
        wr_en       = $urandom_range(0, 1);
        invalidate  = ($urandom_range(0, 19) == 0);
      end
      fill_data = $urandom;
      wr_offset = 4'($urandom);
      wr_be     = 4'($urandom);
      wr_data   = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
